// File: rtl/argon_regfile_mp.sv
// argon_regfile_mp: multi-port register file for the Argon core.
//   - two registered read ports (A, B), one write port
//   - stack-pointer push/pop port with wrap pulse
//   - ALU flags merge port into the low FLAG_BITS of F
// Optional feature macro: ARGON_REGFILE_BYPASS_EN
//   defined   : a read sampled together with an update to the same register
//               returns the post-update value (forwarded from next-state).
//   undefined : such a read returns the pre-update (stored) value.
// r0 has no storage and always reads as zero.

module argon_regfile_mp #(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            NUM_REGS   = 8,
  parameter int unsigned            SP_IDX     = NUM_REGS - 2,
  parameter int unsigned            F_IDX      = NUM_REGS - 1,
  parameter int unsigned            FLAG_BITS  = 8,
  parameter logic [DATA_WIDTH-1:0]  SP_RESET   = '0,
  localparam int unsigned           IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,

  input  logic                  i_RdA_Valid,
  input  logic [IDX_W-1:0]      i_RdA_Idx,
  output logic                  o_RdA_Valid,
  output logic [DATA_WIDTH-1:0] o_RdA_Data,

  input  logic                  i_RdB_Valid,
  input  logic [IDX_W-1:0]      i_RdB_Idx,
  output logic                  o_RdB_Valid,
  output logic [DATA_WIDTH-1:0] o_RdB_Data,

  input  logic                  i_Wr_Valid,
  input  logic [IDX_W-1:0]      i_Wr_Idx,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,

  input  logic [1:0]            i_Sp_Op,
  output logic [DATA_WIDTH-1:0] o_Sp,
  output logic                  o_Sp_Wrap,

  input  logic                  i_Flags_Valid,
  input  logic [FLAG_BITS-1:0]  i_Flags,
  output logic [DATA_WIDTH-1:0] o_Flags
);

  // SP port opcodes; 2'b11 is reserved and behaves as no-op.
  localparam logic [1:0] SpPush = 2'b01;
  localparam logic [1:0] SpPop  = 2'b10;

  // Mask selecting the ALU-owned low bits of F (works for FLAG_BITS == DATA_WIDTH too).
  localparam logic [DATA_WIDTH:0]   FlagOne  = (DATA_WIDTH + 1)'(1) << FLAG_BITS;
  localparam logic [DATA_WIDTH-1:0] FlagMask = DATA_WIDTH'(FlagOne - (DATA_WIDTH + 1)'(1));

  // Storage for r1..rN-1 only; r0 is a constant zero.
  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_q, regs_d;

  // Source for read ports (stored or forwarded) with r0 forced to zero.
  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] rd_src;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rd_view;

  logic [DATA_WIDTH-1:0] sp_cur;
  logic [DATA_WIDTH-1:0] flags_ext;
  logic                  wr_sp;
  logic                  sp_wrap_d, sp_wrap_q;

  logic                  rda_valid_q, rdb_valid_q;
  logic [DATA_WIDTH-1:0] rda_data_q, rdb_data_q;

  assign sp_cur    = regs_q[SP_IDX];
  assign flags_ext = DATA_WIDTH'(i_Flags);
  assign wr_sp     = i_Wr_Valid && (i_Wr_Idx == IDX_W'(SP_IDX));

  // Next-state for all registers: write port, then SP op, then flags merge.
  always_comb begin
    regs_d = regs_q;

    for (int i = 1; i < NUM_REGS; i++) begin
      if (i_Wr_Valid && (i_Wr_Idx == IDX_W'(i))) begin
        regs_d[i] = i_Wr_Data;
      end
    end

    // An explicit write to SP overrides any SP op in the same cycle.
    if (!wr_sp) begin
      case (i_Sp_Op)
        SpPush:  regs_d[SP_IDX] = sp_cur - DATA_WIDTH'(1);
        SpPop:   regs_d[SP_IDX] = sp_cur + DATA_WIDTH'(1);
        default: ;
      endcase
    end

    // Flags merge sits on top of a same-cycle write to F, so upper bits come
    // from the write data and the low bits from the ALU.
    if (i_Flags_Valid) begin
      regs_d[F_IDX] = (regs_d[F_IDX] & ~FlagMask) | (flags_ext & FlagMask);
    end
  end

  // Wrap detection: push from zero or pop from all-ones, unless overridden by a write.
  always_comb begin
    sp_wrap_d = 1'b0;
    if (!wr_sp) begin
      if ((i_Sp_Op == SpPush) && (sp_cur == '0)) begin
        sp_wrap_d = 1'b1;
      end
      if ((i_Sp_Op == SpPop) && (sp_cur == '1)) begin
        sp_wrap_d = 1'b1;
      end
    end
  end

`ifdef ARGON_REGFILE_BYPASS_EN
  assign rd_src = regs_d;
`else
  assign rd_src = regs_q;
`endif

  // Read view indexed directly by the port index, with r0 hardwired to zero.
  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rd_view[i] = rd_src[i];
    end
  end

  // Register file storage; SP resets to SP_RESET, everything else to zero.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Wrap pulse register: high only in the cycle after a wrapping op.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sp_wrap_q <= 1'b0;
    end else begin
      sp_wrap_q <= sp_wrap_d;
    end
  end

  // Read port A: one-cycle latency; data holds until the next accepted request.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rda_valid_q <= 1'b0;
      rda_data_q  <= '0;
    end else begin
      rda_valid_q <= i_RdA_Valid;
      if (i_RdA_Valid) begin
        rda_data_q <= rd_view[i_RdA_Idx];
      end
    end
  end

  // Read port B: identical to port A and fully independent of it.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      rdb_valid_q <= 1'b0;
      rdb_data_q  <= '0;
    end else begin
      rdb_valid_q <= i_RdB_Valid;
      if (i_RdB_Valid) begin
        rdb_data_q <= rd_view[i_RdB_Idx];
      end
    end
  end

  assign o_RdA_Valid = rda_valid_q;
  assign o_RdA_Data  = rda_data_q;
  assign o_RdB_Valid = rdb_valid_q;
  assign o_RdB_Data  = rdb_data_q;
  assign o_Sp        = regs_q[SP_IDX];
  assign o_Sp_Wrap   = sp_wrap_q;
  assign o_Flags     = regs_q[F_IDX];

endmodule

// File: tb/tb_argon_regfile_mp.sv
// Testbench for argon_regfile_mp: read responses are checked by a scoreboard
// monitor; SP/flags/wrap state is compared directly after each update.

module tb_argon_regfile_mp;

  localparam int unsigned DW    = 16;
  localparam int unsigned NR    = 8;
  localparam int unsigned IW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rda_valid_i, rdb_valid_i;
  logic [IW-1:0] rda_idx, rdb_idx;
  logic          rda_valid_o, rdb_valid_o;
  logic [DW-1:0] rda_data, rdb_data;
  logic          wr_valid;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [1:0]    sp_op;
  logic [DW-1:0] sp;
  logic          sp_wrap;
  logic          flags_valid;
  logic [7:0]    flags_in;
  logic [DW-1:0] flags_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  argon_regfile_mp #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .FLAG_BITS  (8),
    .SP_RESET   (16'h00F0)
  ) dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .i_RdA_Valid   (rda_valid_i),
    .i_RdA_Idx     (rda_idx),
    .o_RdA_Valid   (rda_valid_o),
    .o_RdA_Data    (rda_data),
    .i_RdB_Valid   (rdb_valid_i),
    .i_RdB_Idx     (rdb_idx),
    .o_RdB_Valid   (rdb_valid_o),
    .o_RdB_Data    (rdb_data),
    .i_Wr_Valid    (wr_valid),
    .i_Wr_Idx      (wr_idx),
    .i_Wr_Data     (wr_data),
    .i_Sp_Op       (sp_op),
    .o_Sp          (sp),
    .o_Sp_Wrap     (sp_wrap),
    .i_Flags_Valid (flags_valid),
    .i_Flags       (flags_in),
    .o_Flags       (flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rda_valid_i = 1'b0; rda_idx = '0;
    rdb_valid_i = 1'b0; rdb_idx = '0;
    wr_valid = 1'b0; wr_idx = '0; wr_data = '0;
    sp_op = 2'b00;
    flags_valid = 1'b0; flags_in = '0;
  endtask

  // Scoreboard monitor: every valid response pops and compares one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rda_valid_o) begin
        if (exp_a.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rdA_unexpected: got valid with data %h, expected no response", rda_data);
        end else begin
          chk("rdA_data", 32'(rda_data), 32'(exp_a.pop_front()));
        end
      end
      if (rdb_valid_o) begin
        if (exp_b.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rdB_unexpected: got valid with data %h, expected no response", rdb_data);
        end else begin
          chk("rdB_data", 32'(rdb_data), 32'(exp_b.pop_front()));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    #12;
    chk("reset_sp",      32'(sp), 32'h00F0);
    chk("reset_flags",   32'(flags_out), 32'h0);
    chk("reset_wrap",    32'(sp_wrap), 32'h0);
    chk("reset_valid",   {30'd0, rda_valid_o, rdb_valid_o}, 32'h0);
    chk("reset_data",    {rda_data, rdb_data}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Reads of r1..r5 after reset, back-to-back on both ports
    for (int i = 1; i <= 5; i++) begin
      rda_valid_i = 1'b1; rda_idx = IW'(i);
      rdb_valid_i = 1'b1; rdb_idx = IW'(6 - i);
      exp_a.push_back(16'h0);
      exp_b.push_back(16'h0);
      tick();
    end
    idle_inputs();

    // Write r3 then read it on A and r0 on B
    wr_valid = 1'b1; wr_idx = 3'd3; wr_data = 16'hBEEF;
    tick();
    idle_inputs();
    rda_valid_i = 1'b1; rda_idx = 3'd3; exp_a.push_back(16'hBEEF);
    rdb_valid_i = 1'b1; rdb_idx = 3'd0; exp_b.push_back(16'h0000);
    tick();
    idle_inputs();

    // Write to r0 is dropped
    wr_valid = 1'b1; wr_idx = 3'd0; wr_data = 16'h1234;
    tick();
    idle_inputs();
    rda_valid_i = 1'b1; rda_idx = 3'd0; exp_a.push_back(16'h0000);
    rdb_valid_i = 1'b1; rdb_idx = 3'd3; exp_b.push_back(16'hBEEF);
    tick();
    idle_inputs();

    // SP: set to 0, push wraps, pop wraps back, write wins over push
    wr_valid = 1'b1; wr_idx = 3'd6; wr_data = 16'h0000;
    tick();
    idle_inputs();
    chk("sp_write0", 32'(sp), 32'h0000);
    chk("sp_write0_wrap", 32'(sp_wrap), 32'h0);
    sp_op = 2'b01;
    tick();
    idle_inputs();
    chk("sp_push_wrap_val", 32'(sp), 32'hFFFF);
    chk("sp_push_wrap_pulse", 32'(sp_wrap), 32'h1);
    tick();
    chk("sp_push_pulse_end", 32'(sp_wrap), 32'h0);
    sp_op = 2'b10;
    tick();
    idle_inputs();
    chk("sp_pop_wrap_val", 32'(sp), 32'h0000);
    chk("sp_pop_wrap_pulse", 32'(sp_wrap), 32'h1);
    tick();
    chk("sp_pop_pulse_end", 32'(sp_wrap), 32'h0);
    wr_valid = 1'b1; wr_idx = 3'd6; wr_data = 16'h0100; sp_op = 2'b01;
    tick();
    idle_inputs();
    chk("sp_wr_vs_push", 32'(sp), 32'h0100);
    chk("sp_wr_vs_push_wrap", 32'(sp_wrap), 32'h0);
    sp_op = 2'b01;
    tick();
    idle_inputs();
    chk("sp_push_plain", 32'(sp), 32'h00FF);
    chk("sp_push_plain_wrap", 32'(sp_wrap), 32'h0);
    sp_op = 2'b11;
    tick();
    idle_inputs();
    chk("sp_reserved_op", 32'(sp), 32'h00FF);

    // Flags: write F, merge ALU flags, then collision
    wr_valid = 1'b1; wr_idx = 3'd7; wr_data = 16'hAB00;
    tick();
    idle_inputs();
    chk("f_write", 32'(flags_out), 32'hAB00);
    flags_valid = 1'b1; flags_in = 8'h5A;
    tick();
    idle_inputs();
    chk("f_merge", 32'(flags_out), 32'hAB5A);
    wr_valid = 1'b1; wr_idx = 3'd7; wr_data = 16'h1234;
    flags_valid = 1'b1; flags_in = 8'hFF;
    tick();
    idle_inputs();
    chk("f_wr_vs_flags", 32'(flags_out), 32'h12FF);
    rdb_valid_i = 1'b1; rdb_idx = 3'd7; exp_b.push_back(16'h12FF);
    rda_valid_i = 1'b1; rda_idx = 3'd6; exp_a.push_back(16'h00FF);
    tick();
    idle_inputs();

    // Same-cycle write and read of r2
    wr_valid = 1'b1; wr_idx = 3'd2; wr_data = 16'h0001;
    tick();
    idle_inputs();
    wr_valid = 1'b1; wr_idx = 3'd2; wr_data = 16'h0002;
    rda_valid_i = 1'b1; rda_idx = 3'd2;
`ifdef ARGON_REGFILE_BYPASS_EN
    exp_a.push_back(16'h0002);
`else
    exp_a.push_back(16'h0001);
`endif
    tick();
    idle_inputs();
    rda_valid_i = 1'b1; rda_idx = 3'd2; exp_a.push_back(16'h0002);
    tick();
    idle_inputs();
    tick();
    tick();

    // Async reset between request and response edge
    rda_valid_i = 1'b1; rda_idx = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rda_valid_o), 32'h0);
    chk("rst_mid_data",  32'(rda_data), 32'h0);
    tick();
    chk("rst_mid_valid_after", 32'(rda_valid_o), 32'h0);
    chk("rst_mid_data_after",  32'(rda_data), 32'h0);
    chk("rst_mid_sp", 32'(sp), 32'h00F0);
    idle_inputs();
    #2;
    rst_n = 1'b1;
    tick();
    rda_valid_i = 1'b1; rda_idx = 3'd3; exp_a.push_back(16'h0000);
    tick();
    idle_inputs();
    tick();
    tick();

    chk("scoreboard_a_drained", 32'(exp_a.size()), 32'h0);
    chk("scoreboard_b_drained", 32'(exp_b.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/argon_regfile_mp.md
# argon_regfile_mp

Parametrised multi-port register file for the Argon core, successor to the single-bus register file. Provides two independent registered read ports, one write port, a dedicated stack-pointer push/pop port with wrap detection, and a flags merge port fed by the ALU. It sits between the decode/control unit and the ALU, replacing the command-multiplexed bus access with concurrent per-cycle access.

## Interface
Parameters:
- DATA_WIDTH, 16, register width in bits
- NUM_REGS, 8, register count; power of two, ≥ 4; index width IDX_W = $clog2(NUM_REGS)
- SP_IDX, NUM_REGS-2, index of stack pointer
- F_IDX, NUM_REGS-1, index of flags register
- FLAG_BITS, 8, low bits of F owned by the ALU flags port; ≤ DATA_WIDTH
- SP_RESET, 0, reset value of SP

Ports:
- i_Clk  in  1  clock, rising edge
- i_Reset_n  in  1  asynchronous, active-low reset
- i_RdA_Valid  in  1  read request, port A
- i_RdA_Idx  in  IDX_W  register index, port A
- o_RdA_Valid  out  1  read data valid, port A
- o_RdA_Data  out  DATA_WIDTH  read data, port A
- i_RdB_Valid / i_RdB_Idx / o_RdB_Valid / o_RdB_Data  same as port A, port B
- i_Wr_Valid  in  1  write strobe
- i_Wr_Idx  in  IDX_W  write index
- i_Wr_Data  in  DATA_WIDTH  write data
- i_Sp_Op  in  2  00 none, 01 push (SP−1), 10 pop (SP+1), 11 reserved (no-op)
- o_Sp  out  DATA_WIDTH  current SP, combinational from register
- o_Sp_Wrap  out  1  one-cycle pulse: push from 0 or pop from all-ones
- i_Flags_Valid  in  1  ALU flags update strobe
- i_Flags  in  FLAG_BITS  ALU flags
- o_Flags  out  DATA_WIDTH  current F, combinational from register

## Operation
- r0 reads as zero always; writes to index 0 are silently dropped (no storage for r0).
- Write: on i_Wr_Valid, register[i_Wr_Idx] ← i_Wr_Data at the clock edge.
- SP op: push/pop modify SP modulo 2^DATA_WIDTH; wrap raises o_Sp_Wrap next cycle, SP still wraps.
- Flags: on i_Flags_Valid, F[FLAG_BITS-1:0] ← i_Flags; upper F bits untouched.
- Same-cycle collisions on one register, resolved per cycle:
  - Write to SP + SP op: explicit write wins, SP op discarded, no wrap pulse.
  - Write to F + flags update: F upper bits from i_Wr_Data, low FLAG_BITS from i_Flags.
- Reads: each port independent; both ports may read the same index; reads never stall.
- Index out of range is impossible (NUM_REGS power of two).

## Timing
- Reset (i_Reset_n low, async): all registers 0 except SP = SP_RESET; o_RdA/B_Valid 0, o_RdA/B_Data 0, o_Sp_Wrap 0. Reset asserted mid-operation aborts pending reads; no valid pulse follows.
- Read latency 1 cycle: request sampled at edge N, o_RdX_Valid high for exactly cycle N+1 with data; o_RdX_Data holds its last value until the next accepted request.
- Back-to-back requests every cycle supported; valid stays high continuously.
- Write, SP, flags updates visible on o_Sp/o_Flags the cycle after the strobe.
- o_Sp_Wrap: registered, high only the cycle after the wrapping op.

## Configuration
- ARGON_REGFILE_BYPASS_EN defined: a read sampled in the same cycle as an update to the same register returns the post-update value (write data, SP after op, merged F).
- Undefined: such a read returns the pre-update value; new value visible to reads requested the following cycle. Saves the forwarding muxes.

## Test plan
- Reset: drive i_Reset_n low with SP_RESET=16'h00F0 → SP=0x00F0, F=0, reads of r1..r5 return 0, all valids 0.
- Write r3=0xBEEF, next cycle read A idx 3 and B idx 0 → one cycle later o_RdA_Data=0xBEEF, o_RdB_Data=0, both valids 1; write to r0 of 0x1234 then read r0 → 0.
- SP: from 0, push → SP=0xFFFF and o_Sp_Wrap pulses once; pop → SP=0x0000 with wrap pulse; same-cycle write SP=0x0100 and push → SP=0x0100, no pulse.
- Flags: F=0xAB00 via write port, then i_Flags=0x5A → F=0xAB5A; same-cycle write F=0x1234 and i_Flags=0xFF → F=0x12FF.
- Bypass: r2=0x0001, same cycle write r2=0x0002 and read A idx 2 → 0x0002 with ARGON_REGFILE_BYPASS_EN, 0x0001 without.
- Async reset mid-read: assert i_Reset_n low between request and response edge → o_RdA_Valid stays 0, data 0.
